layer_cfg_sequencer: RTL and testbench
======================================

// Module: layer_cfg_sequencer
// PURPOSE
//  Runtime replacement for the hard-wired system config: host streams 32-bit config words into a shadow bank.
//  Block then commits them atomically to the active config bus driving DFSM/SSP/buffers/PE/ports.
//  Double-buffered: next layer loads while current layer runs; commit at layer boundary, then datapath start.
// PARAMETERS
//  CFG_BITS   901  active config width (23 dfsm+20 ssp+38 quabuf+26 singbuf+4 flags+6 pe+14x56 ports)
//  NUM_WORDS  29   shadow words = ceil(CFG_BITS/32)
//  CNT_W      16   layer counter width
// PORTS
//  clk          in   1         clock
//  rst_n        in   1         async active-low reset
//  cfg_valid    in   1         host write valid
//  cfg_ready    out  1         host write ready
//  cfg_addr     in   5         word index
//  cfg_data     in   32        word data
//  cfg_arm      in   1         pulse: shadow complete, commit when datapath free
//  err_clr      in   1         clears sticky errors
//  dp_done      in   1         pulse: datapath finished layer
//  dp_start     out  1         pulse: datapath begin layer with new config
//  cfg_active   out  CFG_BITS  committed config, field offsets per package
//  armed        out  1         commit pending
//  busy         out  1         state != IDLE
//  layer_cnt    out  CNT_W     commits since reset
//  err_addr     out  1         sticky: write with cfg_addr >= NUM_WORDS
//  err_incomp   out  1         sticky: arm with words missing
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; cfg_active, shadow, wr_mask, armed, dp_start, layer_cnt, errs all 0.
//  Reset mid-layer discards pending arm.
//  FSM: IDLE, COMMIT, RUN.
//  - IDLE: armed=1 -> COMMIT.
//  - COMMIT (1 cycle): cfg_active<=shadow (bits >= CFG_BITS of last word dropped); wr_mask<=0; armed<=0; layer_cnt++ (wraps); -> RUN; dp_start=1 registered, high exactly the first RUN cycle.
//  - RUN: dp_done & armed -> COMMIT; dp_done & !armed -> IDLE.
//  dp_done outside RUN is ignored.
//  cfg_ready = !armed && state!=COMMIT (combinational from regs). Writes are therefore accepted in IDLE and RUN.
//  Write handshake: transfer on cfg_valid&cfg_ready.
//  - addr < NUM_WORDS: shadow[addr]<=data, wr_mask[addr]<=1.
//  - Otherwise discarded, err_addr<=1. cfg_ready is not lowered.
//  - Rewriting a word is allowed; last write wins.
//  cfg_arm, when armed=0 and state!=COMMIT: evaluated against wr_mask including a write accepted the same cycle.
//  - Full -> armed<=1.
//  - Else err_incomp<=1, arm ignored.
//  - cfg_arm while armed or in COMMIT is ignored, no error.
//  Latency: arm sampled in IDLE at cycle t -> COMMIT at t+1 -> cfg_active valid and dp_start=1 at t+2.
//  Simultaneous: dp_done and valid cfg_arm in the same RUN cycle -> COMMIT next cycle.
//  err_clr and an error event in the same cycle -> error stays set.
//  cfg_active is stable except on COMMIT. Datapath samples it only after dp_start.
// STRUCTURE
//  arthas_cfg_pkg:
//  - CFG_BITS, NUM_WORDS
//  - localparam offset/width per field: DFSM, SSP, QUABUF, SINGBUF, MODE_CONV_MM, ISAC, ISRELU, ISBN, PE_1_1..PE_2_3, IPORT_0..11, OPORT_0..1
//  - state enum seq_state_t {IDLE, COMMIT, RUN}
//  Sub-module cfg_word_bank: NUM_WORDS x 32 shadow regs + wr_mask + full flag. Sequencer holds FSM, counters, active reg.
//  Field slicing of cfg_active is done by consumers using package offsets, not here.
// TESTING
//  1. Write words 0..28 (data=idx*0x01010101), arm in IDLE:
//     - dp_start one cycle at t+2
//     - cfg_active matches concatenation, top 27 bits of word 28 dropped
//     - layer_cnt=1
//  2. Write 28 words (skip 7), arm -> err_incomp=1, armed=0, no dp_start.
//     Write word 7, arm -> commit proceeds.
//  3. During RUN load all words, arm:
//     - armed=1, cfg_ready=0, cfg_active unchanged
//     - dp_done -> COMMIT next cycle, dp_start next, RUN continues
//  4. Write addr 29 -> err_addr=1, shadow unchanged.
//     err_clr -> 0.
//     err_clr coincident with addr 31 write -> stays 1.
//  5. Assert rst_n=0 mid-RUN with armed=1:
//     - all outputs 0 immediately (async), state IDLE
//     - after release, arm without writes -> err_incomp
//  6. dp_done pulse in IDLE ignored.
//     dp_done with cfg_arm (mask full) same RUN cycle -> commit.
//     Force layer_cnt 0xFFFF, commit -> 0x0000.

Source files
------------

// File: rtl/layer_cfg_sequencer_pkg.sv
// Shared constants for the layer config sequencer: config geometry, field map of
// the committed config vector, and the sequencer state encoding.
package layer_cfg_sequencer_pkg;

  localparam int CFG_BITS  = 901;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = (CFG_BITS + WORD_W - 1) / WORD_W;
  localparam int ADDR_W    = 5;
  localparam int SEQ_CNT_W = 16;

  // Only the low LAST_W bits of the final shadow word reach cfg_active.
  localparam int LAST_W    = CFG_BITS - (NUM_WORDS - 1) * WORD_W;

  // Field map of cfg_active, LSB first.
  localparam int DFSM_OFF         = 0;
  localparam int DFSM_W           = 23;
  localparam int SSP_OFF          = DFSM_OFF + DFSM_W;
  localparam int SSP_W            = 20;
  localparam int QUABUF_OFF       = SSP_OFF + SSP_W;
  localparam int QUABUF_W         = 38;
  localparam int SINGBUF_OFF      = QUABUF_OFF + QUABUF_W;
  localparam int SINGBUF_W        = 26;
  localparam int MODE_CONV_MM_OFF = SINGBUF_OFF + SINGBUF_W;
  localparam int ISAC_OFF         = MODE_CONV_MM_OFF + 1;
  localparam int ISRELU_OFF       = ISAC_OFF + 1;
  localparam int ISBN_OFF         = ISRELU_OFF + 1;
  localparam int FLAG_W           = 1;
  localparam int PE_1_1_OFF       = ISBN_OFF + 1;
  localparam int PE_1_2_OFF       = PE_1_1_OFF + 1;
  localparam int PE_1_3_OFF       = PE_1_2_OFF + 1;
  localparam int PE_2_1_OFF       = PE_1_3_OFF + 1;
  localparam int PE_2_2_OFF       = PE_2_1_OFF + 1;
  localparam int PE_2_3_OFF       = PE_2_2_OFF + 1;
  localparam int PE_W             = 1;
  localparam int PORT_W           = 56;
  localparam int PORT_BASE        = PE_2_3_OFF + PE_W;
  localparam int IPORT_0_OFF      = PORT_BASE + 0 * PORT_W;
  localparam int IPORT_1_OFF      = PORT_BASE + 1 * PORT_W;
  localparam int IPORT_2_OFF      = PORT_BASE + 2 * PORT_W;
  localparam int IPORT_3_OFF      = PORT_BASE + 3 * PORT_W;
  localparam int IPORT_4_OFF      = PORT_BASE + 4 * PORT_W;
  localparam int IPORT_5_OFF      = PORT_BASE + 5 * PORT_W;
  localparam int IPORT_6_OFF      = PORT_BASE + 6 * PORT_W;
  localparam int IPORT_7_OFF      = PORT_BASE + 7 * PORT_W;
  localparam int IPORT_8_OFF      = PORT_BASE + 8 * PORT_W;
  localparam int IPORT_9_OFF      = PORT_BASE + 9 * PORT_W;
  localparam int IPORT_10_OFF     = PORT_BASE + 10 * PORT_W;
  localparam int IPORT_11_OFF     = PORT_BASE + 11 * PORT_W;
  localparam int OPORT_0_OFF      = PORT_BASE + 12 * PORT_W;
  localparam int OPORT_1_OFF      = PORT_BASE + 13 * PORT_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    RUN    = 2'd2
  } seq_state_t;

endpackage

// File: rtl/layer_cfg_sequencer_if.sv
// Host config-write channel into the shadow bank.
interface layer_cfg_sequencer_if;
  import layer_cfg_sequencer_pkg::*;

  // A word transfers on any rising clk edge where cfg_valid && cfg_ready; the host
  // holds addr/data stable while valid is high and ready never depends on valid.
  logic              cfg_valid;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_addr;
  logic [WORD_W-1:0] cfg_data;

  modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);

endinterface

// File: rtl/layer_cfg_sequencer_cfg_word_bank.sv
// Shadow register bank: NUM_WORDS config words plus a written-word mask. Only the
// bits that survive into cfg_active are stored for the final word.
module cfg_word_bank
  import layer_cfg_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WORD_W-1:0]   wr_data,
  input  logic                clr_mask,
  output logic [CFG_BITS-1:0] shadow_cfg,
  output logic                full_with_wr
);

  logic [WORD_W-1:0]    words_q [NUM_WORDS-1];
  logic [LAST_W-1:0]    last_q;
  logic [NUM_WORDS-1:0] mask_q;
  logic [NUM_WORDS-1:0] wr_onehot;

  always_comb begin
    wr_onehot = '0;
    if (wr_en) wr_onehot[wr_addr] = 1'b1;
  end

  // Completeness counts a write landing this same cycle.
  assign full_with_wr = &(mask_q | wr_onehot);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '{default: '0};
      last_q  <= '0;
    end else if (wr_en) begin
      if (wr_addr == ADDR_W'(NUM_WORDS - 1)) last_q <= wr_data[LAST_W-1:0];
      else                                   words_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        mask_q <= '0;
    else if (clr_mask) mask_q <= '0;
    else               mask_q <= mask_q | wr_onehot;
  end

  always_comb begin
    shadow_cfg = '0;
    for (int i = 0; i < NUM_WORDS - 1; i++) shadow_cfg[i*WORD_W +: WORD_W] = words_q[i];
    shadow_cfg[CFG_BITS-1 -: LAST_W] = last_q;
  end

endmodule

// File: rtl/layer_cfg_sequencer.sv
// Double-buffered layer config sequencer: host fills the shadow bank while the
// datapath runs, then an armed shadow is committed atomically at the layer boundary.
module layer_cfg_sequencer
  import layer_cfg_sequencer_pkg::*;
#(
  parameter int CNT_W = SEQ_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  layer_cfg_sequencer_if.slave  host,
  input  logic                  cfg_arm,
  input  logic                  err_clr,
  input  logic                  dp_done,
  output logic                  dp_start,
  output logic [CFG_BITS-1:0]   cfg_active,
  output logic                  armed,
  output logic                  busy,
  output logic [CNT_W-1:0]      layer_cnt,
  output logic                  err_addr,
  output logic                  err_incomp,
  output seq_state_t            state_dbg
);

  seq_state_t          state_q, state_d;
  logic                armed_q, dp_start_q, err_addr_q, err_incomp_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CFG_BITS-1:0] active_q;
  logic [CFG_BITS-1:0] shadow_cfg;
  logic                full_with_wr;
  logic                commit;
  logic                wr_fire, wr_good, wr_bad;
  logic                arm_eval, arm_set, arm_err;

  assign host.cfg_ready = !armed_q && (state_q != COMMIT);

  assign wr_fire  = host.cfg_valid && host.cfg_ready;
  assign wr_good  = wr_fire && (host.cfg_addr < ADDR_W'(NUM_WORDS));
  assign wr_bad   = wr_fire && !wr_good;

  // An arm is only judged when no commit is pending or in flight.
  assign arm_eval = cfg_arm && !armed_q && (state_q != COMMIT);
  assign arm_set  = arm_eval && full_with_wr;
  assign arm_err  = arm_eval && !full_with_wr;

  cfg_word_bank u_bank (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_good),
    .wr_addr      (host.cfg_addr),
    .wr_data      (host.cfg_data),
    .clr_mask     (commit),
    .shadow_cfg   (shadow_cfg),
    .full_with_wr (full_with_wr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A successful arm counts as pending in the same cycle so IDLE reaches COMMIT
  // one cycle after the arm and the datapath starts one cycle later.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (armed_q || arm_set) state_d = COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (dp_done) state_d = (armed_q || arm_set) ? COMMIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q    <= 1'b0;
      dp_start_q <= 1'b0;
      cnt_q      <= '0;
      active_q   <= '0;
    end else begin
      dp_start_q <= commit;
      if (commit) begin
        armed_q  <= 1'b0;
        cnt_q    <= cnt_q + CNT_W'(1);
        active_q <= shadow_cfg;
      end else if (arm_set) begin
        armed_q  <= 1'b1;
      end
    end
  end

  // Error set beats a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_addr_q   <= 1'b0;
      err_incomp_q <= 1'b0;
    end else begin
      if (wr_bad)       err_addr_q   <= 1'b1;
      else if (err_clr) err_addr_q   <= 1'b0;
      if (arm_err)      err_incomp_q <= 1'b1;
      else if (err_clr) err_incomp_q <= 1'b0;
    end
  end

  assign dp_start   = dp_start_q;
  assign cfg_active = active_q;
  assign armed      = armed_q;
  assign busy       = (state_q != IDLE);
  assign layer_cnt  = cnt_q;
  assign err_addr   = err_addr_q;
  assign err_incomp = err_incomp_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_layer_cfg_sequencer.sv
// Directed bench for layer_cfg_sequencer: commits are scoreboarded against a
// shadow-bank model, control/error behaviour is checked inline.
module tb_layer_cfg_sequencer;
  import layer_cfg_sequencer_pkg::*;

  localparam int CW = SEQ_CNT_W;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_arm = 1'b0;
  logic                err_clr = 1'b0;
  logic                dp_done = 1'b0;
  logic                dp_start, armed, busy, err_addr, err_incomp;
  logic [CFG_BITS-1:0] cfg_active;
  logic [CW-1:0]       layer_cnt;
  seq_state_t          state_dbg;

  layer_cfg_sequencer_if host ();

  layer_cfg_sequencer #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host       (host),
    .cfg_arm    (cfg_arm),
    .err_clr    (err_clr),
    .dp_done    (dp_done),
    .dp_start   (dp_start),
    .cfg_active (cfg_active),
    .armed      (armed),
    .busy       (busy),
    .layer_cnt  (layer_cnt),
    .err_addr   (err_addr),
    .err_incomp (err_incomp),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int                     checks = 0;
  int                     failures = 0;
  logic [CFG_BITS+CW-1:0] exp_q[$];
  logic [WORD_W-1:0]      shadow_m [NUM_WORDS];
  logic [CFG_BITS-1:0]    pend_active;
  logic [CFG_BITS-1:0]    last_active;
  logic [CW-1:0]          exp_cnt;
  logic [CFG_BITS+CW-1:0] mon_e;
  logic [NUM_WORDS*WORD_W-1:0] pad_a, pad_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [CFG_BITS-1:0] build_exp();
    logic [NUM_WORDS*WORD_W-1:0] t;
    for (int i = 0; i < NUM_WORDS; i++) t[i*WORD_W +: WORD_W] = shadow_m[i];
    return t[CFG_BITS-1:0];
  endfunction

  // Monitor: every dp_start must match the oldest expected commit.
  always @(negedge clk) begin
    if (rst_n && dp_start) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_dp_start act=1 exp=0");
      end else begin
        mon_e = exp_q.pop_front();
        if ({cfg_active, layer_cnt} !== mon_e) begin
          failures++;
          pad_a = '0; pad_a[CFG_BITS-1:0] = cfg_active;
          pad_e = '0; pad_e[CFG_BITS-1:0] = mon_e[CFG_BITS+CW-1:CW];
          for (int w = 0; w < NUM_WORDS; w++) begin
            if (pad_a[w*WORD_W +: WORD_W] !== pad_e[w*WORD_W +: WORD_W]) begin
              $display("FAIL commit_cfg word=%0d act=%h exp=%h", w,
                       pad_a[w*WORD_W +: WORD_W], pad_e[w*WORD_W +: WORD_W]);
              break;
            end
          end
          if (layer_cnt !== mon_e[CW-1:0])
            $display("FAIL commit_cnt act=%0h exp=%0h", layer_cnt, mon_e[CW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
    host.cfg_valid = 1'b1;
    host.cfg_addr  = a;
    host.cfg_data  = d;
    check("wr_ready", host.cfg_ready, 1);
    tick();
    host.cfg_valid = 1'b0;
    if (a < ADDR_W'(NUM_WORDS)) shadow_m[a] = d;
  endtask

  task automatic write_all(input logic [WORD_W-1:0] base, input logic [WORD_W-1:0] step);
    for (int i = 0; i < NUM_WORDS; i++) write_word(ADDR_W'(i), base + WORD_W'(i) * step);
  endtask

  task automatic push_commit();
    exp_cnt     = exp_cnt + CW'(1);
    pend_active = build_exp();
    exp_q.push_back({pend_active, exp_cnt});
  endtask

  task automatic arm_idle_commit();
    push_commit();
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
    check("idle_arm_to_commit", state_dbg, COMMIT);
    check("commit_no_start_yet", dp_start, 0);
    check("commit_ready_low", host.cfg_ready, 0);
    tick();
    check("start_at_t2", dp_start, 1);
    check("run_after_commit", state_dbg, RUN);
    check("layer_cnt_after_commit", layer_cnt, exp_cnt);
    tick();
    check("start_one_cycle", dp_start, 0);
    last_active = pend_active;
  endtask

  task automatic done_commit();
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    check("done_to_commit", state_dbg, COMMIT);
    tick();
    check("run_start", dp_start, 1);
    check("run_continues", state_dbg, RUN);
    check("run_layer_cnt", layer_cnt, exp_cnt);
    last_active = pend_active;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    host.cfg_valid = 1'b0;
    host.cfg_addr  = '0;
    host.cfg_data  = '0;
    exp_cnt        = '0;
    last_active    = '0;
    for (int i = 0; i < NUM_WORDS; i++) shadow_m[i] = '0;

    tick();
    tick();
    check("rst_dp_start", dp_start, 0);
    check("rst_armed", armed, 0);
    check("rst_busy", busy, 0);
    check("rst_layer_cnt", layer_cnt, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_err_incomp", err_incomp, 0);
    check("rst_active_zero", (cfg_active == '0), 1);
    check("rst_state", state_dbg, IDLE);
    check("rst_ready", host.cfg_ready, 1);
    rst_n = 1'b1;
    tick();

    // 1: full load and commit from IDLE
    write_all(32'h0, 32'h01010101);
    arm_idle_commit();
    check("t1_word0", cfg_active[31:0], 32'h0);
    check("t1_word1", cfg_active[63:32], 32'h01010101);
    check("t1_word27", cfg_active[895:864], 32'h1B1B1B1B);
    check("t1_word28_low5", cfg_active[900:896], 5'h1C);
    check("t1_layer_cnt", layer_cnt, 1);

    // 2: incomplete arm is rejected, completing the bank lets it through
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    check("t2_back_to_idle", state_dbg, IDLE);
    for (int i = 0; i < NUM_WORDS; i++)
      if (i != 7) write_word(ADDR_W'(i), 32'hA000_0000 + WORD_W'(i));
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
    check("t2_err_incomp", err_incomp, 1);
    check("t2_not_armed", armed, 0);
    check("t2_stay_idle", state_dbg, IDLE);
    tick();
    check("t2_no_start", dp_start, 0);
    write_word(5'd7, 32'hA000_0007);
    arm_idle_commit();
    pulse_err_clr();
    check("t2_err_cleared", err_incomp, 0);

    // 3: load and arm while running, commit at dp_done
    write_all(32'h5, 32'h02020202);
    push_commit();
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
    check("t3_armed", armed, 1);
    check("t3_ready_low", host.cfg_ready, 0);
    check("t3_still_run", state_dbg, RUN);
    check("t3_active_held", (cfg_active === last_active), 1);
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
    check("t3_rearm_no_err", err_incomp, 0);
    done_commit();

    // 4: out-of-range writes set a sticky error and leave the shadow alone
    write_all(32'hC0DE_0000, 32'h0000_0101);
    write_word(5'd29, 32'hDEAD_BEEF);
    check("t4_err_addr", err_addr, 1);
    check("t4_ready_kept", host.cfg_ready, 1);
    pulse_err_clr();
    check("t4_err_addr_clr", err_addr, 0);
    err_clr = 1'b1;
    write_word(5'd31, 32'h1234_5678);
    err_clr = 1'b0;
    check("t4_set_beats_clr", err_addr, 1);
    pulse_err_clr();
    check("t4_err_addr_clr2", err_addr, 0);
    push_commit();
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
    check("t4_armed", armed, 1);
    done_commit();

    // 5: asynchronous reset while a commit is pending
    write_all(32'h3333_0000, 32'h1);
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
    check("t5_armed_pre", armed, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_armed", armed, 0);
    check("t5_busy", busy, 0);
    check("t5_dp_start", dp_start, 0);
    check("t5_layer_cnt", layer_cnt, 0);
    check("t5_active_zero", (cfg_active == '0), 1);
    check("t5_state", state_dbg, IDLE);
    check("t5_ready", host.cfg_ready, 1);
    exp_cnt = '0;
    for (int i = 0; i < NUM_WORDS; i++) shadow_m[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
    check("t5_incomp_after_rst", err_incomp, 1);
    check("t5_not_armed", armed, 0);
    check("t5_idle", busy, 0);
    pulse_err_clr();

    // 6: dp_done ignored in IDLE, counter wrap, done+arm in the same cycle
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    check("t6_done_ignored", state_dbg, IDLE);
    check("t6_no_start", dp_start, 0);
    force dut.cnt_q = 16'hFFFF;
    tick();
    release dut.cnt_q;
    exp_cnt = 16'hFFFF;
    check("t6_cnt_forced", layer_cnt, 16'hFFFF);
    write_all(32'h4444_0000, 32'h3);
    arm_idle_commit();
    check("t6_cnt_wrapped", layer_cnt, 0);
    write_all(32'h5555_0000, 32'h5);
    push_commit();
    dp_done = 1'b1;
    cfg_arm = 1'b1;
    tick();
    dp_done = 1'b0;
    cfg_arm = 1'b0;
    check("t6_same_cycle_commit", state_dbg, COMMIT);
    tick();
    check("t6_start", dp_start, 1);
    check("t6_layer_cnt", layer_cnt, 1);
    last_active = pend_active;

    tick();
    tick();
    check("queue_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
